// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial sequencer around an external combinational 4-bit adder (Add4).
// Optional subtract mode under `ifdef NIBBLE_ADD_SUB_EN (adds in_sub port).
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_ci,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [NIB-1:0][3:0] a;
        logic [NIB-1:0][3:0] b;
        logic                ci;
        logic                sub;
    } op_t;

    state_t              state;
    op_t                 op;
    logic [CW-1:0]       cnt;
    logic                carry_reg;
    logic [NIB-1:0][3:0] sum_n;
    logic                nxt_sub;
    logic                nxt_ci;

`ifdef NIBBLE_ADD_SUB_EN
    assign nxt_sub = in_sub;
`else
    assign nxt_sub = 1'b0;
`endif
    // Subtract is A + ~B + 1, so the forced carry-in replaces in_ci.
    assign nxt_ci = nxt_sub ? 1'b1 : in_ci;

    // Gated by rst_n so no handshake is offered while reset is held.
    assign in_ready = rst_n && (state == IDLE);
    assign out_sum  = sum_n;

    // Adder is combinational; drive it straight from registered state.
    always_comb begin
        add_a  = 4'h0;
        add_b  = 4'h0;
        add_ci = 1'b0;
        if (state == RUN) begin
            add_a  = op.a[cnt];
            add_b  = op.sub ? ~op.b[cnt] : op.b[cnt];
            add_ci = (cnt == '0) ? op.ci : carry_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            cnt       <= '0;
            carry_reg <= 1'b0;
            sum_n     <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op.a   <= in_a;
                        op.b   <= in_b;
                        op.ci  <= nxt_ci;
                        op.sub <= nxt_sub;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_n[cnt] <= add_sum;
                    carry_reg  <= add_cout;
                    if (cnt == LAST) begin
                        out_cout  <= add_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= '0;
                        carry_reg <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with a behavioural Add4 on the adder port.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
`ifdef NIBBLE_ADD_SUB_EN
    logic             in_sub;
`endif
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_ci;
    logic [3:0]       add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    int checks = 0;
    int errors = 0;
    logic [3:0] seq_a  [NIB];
    logic       seq_ci [NIB];
    logic       ov_early;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
`ifdef NIBBLE_ADD_SUB_EN
        .in_sub(in_sub),
`endif
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, record the RUN-cycle adder drive, end sampled in DONE.
    task automatic start(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub);
        in_a = a; in_b = b; in_ci = ci;
`ifdef NIBBLE_ADD_SUB_EN
        in_sub = sub;
`else
        if (sub) $display("note: sub ignored without NIBBLE_ADD_SUB_EN");
`endif
        in_valid = 1'b1;
        chk("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        ov_early = 1'b0;
        for (int k = 0; k < NIB; k++) begin
            seq_a[k]  = add_a;
            seq_ci[k] = add_ci;
            ov_early  = ov_early | out_valid | in_ready;
            tick();
        end
        chk("run_no_valid_ready", 32'(ov_early), 32'd0);
        chk("out_valid_latency", 32'(out_valid), 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_idle", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_ci = 1'b0;
        out_ready = 1'b0;
`ifdef NIBBLE_ADD_SUB_EN
        in_sub = 1'b0;
`endif
        // Reset held with in_valid high: nothing may be accepted.
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        tick();
        chk("idle_add_a", 32'(add_a), 32'd0);
        chk("idle_add_ci", 32'(add_ci), 32'd0);
        chk("idle_no_accept", 32'(in_ready), 32'd1);

        // Basic add.
        start(16'h1234, 16'h0001, 1'b0, 1'b0);
        chk("basic_sum", 32'(out_sum), 32'h1235);
        chk("basic_cout", 32'(out_cout), 32'd0);
        chk("basic_a_seq", {16'h0, seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 32'h4321);
        release_result();

        // Full ripple, out_ready held high before DONE.
        out_ready = 1'b1;
        start(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        chk("ripple_sum", 32'(out_sum), 32'h0000);
        chk("ripple_cout", 32'(out_cout), 32'd1);
        chk("ripple_ci_seq", {28'h0, seq_ci[0], seq_ci[1], seq_ci[2], seq_ci[3]}, 32'hF);
        tick();
        chk("ripple_one_cycle_valid", 32'(out_valid), 32'd0);
        chk("ripple_idle", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Backpressure with a second request pending.
        start(16'h00FF, 16'h0001, 1'b0, 1'b0);
        in_valid = 1'b1; in_a = 16'h5555; in_b = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(out_sum), 32'h0100);
            chk("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_sum_kept", 32'(out_sum), 32'h0100);
        tick();
        chk("bp_second_ignored", 32'(in_ready), 32'd1);

        // Reset after the second RUN edge discards the partial result.
        in_a = 16'hABCD; in_b = 16'h1111; in_ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_sum", 32'(out_sum), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        ov_early = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ov_early = ov_early | out_valid;
            tick();
        end
        chk("midrst_no_pulse", 32'(ov_early), 32'd0);
        start(16'h0002, 16'h0003, 1'b0, 1'b0);
        chk("midrst_fresh_sum", 32'(out_sum), 32'h0005);
        release_result();

`ifdef NIBBLE_ADD_SUB_EN
        start(16'h0005, 16'h0007, 1'b0, 1'b1);
        chk("sub_neg_sum", 32'(out_sum), 32'hFFFE);
        chk("sub_neg_cout", 32'(out_cout), 32'd0);
        release_result();
        start(16'h0007, 16'h0005, 1'b0, 1'b1);
        chk("sub_pos_sum", 32'(out_sum), 32'h0002);
        chk("sub_pos_cout", 32'(out_cout), 32'd1);
        release_result();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
